// File: rtl/vscale_mul_div_param.sv
// Iterative multiply/divide unit retiring BITS_PER_CYCLE bits per compute cycle.
// Divide-by-zero and signed-overflow divides are resolved at capture, so they skip COMPUTE.
module vscale_mul_div_param #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [1:0]      req_out_sel,
    input  logic            req_in_1_signed,
    input  logic            req_in_2_signed,
    input  logic [XLEN-1:0] req_in_1,
    input  logic [XLEN-1:0] req_in_2,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result
);

    localparam int BPC   = BITS_PER_CYCLE;
    localparam int ITER  = XLEN / BPC;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [1:0] OP_DIV  = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] SEL_HI  = 2'd1;
    localparam logic [1:0] SEL_REM = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_SETUP, S_DONE} state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]  counter;
    logic              op_div;      // DIV/REM datapath instead of MUL
    logic              negate;
    logic              special;     // acc already holds the final bypass result
    logic [1:0]        out_sel;
    logic [XLEN-1:0]   a_reg;       // multiplicand, or dividend shifted out MSB-first
    logic [XLEN-1:0]   b_reg;       // multiplier shifted out MSB-first, or divisor
    logic [2*XLEN-1:0] acc;         // product, or quotient bits
    logic [2*XLEN-1:0] rem;         // partial remainder, low XLEN bits significant
    logic [XLEN-1:0]   result;

    // capture-time decode
    logic              accept;
    logic              is_divrem;
    logic              sign_1, sign_2;
    logic [XLEN-1:0]   abs_1, abs_2;
    logic              div_zero, overflow, special_cap;
    logic [XLEN-1:0]   special_val;
    logic              negate_cap;

    // per-cycle datapath
    logic [2*XLEN-1:0] mul_acc, div_acc;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] src, signed_src;
    logic [XLEN-1:0]   final_result;

    assign resp_result = result;

    // Decode the incoming request: operand magnitudes, result sign and bypass cases.
    always_comb begin
        is_divrem   = (req_op == OP_DIV) || (req_op == OP_REM);
        sign_1      = req_in_1_signed && req_in_1[XLEN-1];
        sign_2      = req_in_2_signed && req_in_2[XLEN-1];
        abs_1       = sign_1 ? -req_in_1 : req_in_1;
        abs_2       = sign_2 ? -req_in_2 : req_in_2;
        negate_cap  = (req_op == OP_REM) ? sign_1 : (sign_1 ^ sign_2);
        div_zero    = is_divrem && (req_in_2 == '0);
        overflow    = is_divrem && req_in_1_signed && req_in_2_signed &&
                      (req_in_1 == {1'b1, {(XLEN-1){1'b0}}}) && (&req_in_2);
        special_cap = div_zero || overflow;
        if (div_zero)
            special_val = (req_op == OP_REM) ? req_in_1 : '1;
        else
            special_val = (req_op == OP_REM) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One compute cycle: BPC shifted partial products for MUL, BPC chained restoring steps for DIV.
    always_comb begin
        logic [XLEN:0]     trial;
        logic [XLEN-1:0]   part;
        logic [BPC-1:0]    qbits;
        mul_acc = acc << BPC;
        part    = rem[XLEN-1:0];
        qbits   = '0;
        trial   = '0;
        for (int j = BPC - 1; j >= 0; j--) begin
            if (b_reg[XLEN-BPC+j])
                mul_acc = mul_acc + ({{XLEN{1'b0}}, a_reg} << j);
        end
        for (int j = 0; j < BPC; j++) begin
            trial = {part, a_reg[XLEN-1-j]};
            if (trial >= {1'b0, b_reg}) begin
                trial            = trial - {1'b0, b_reg};
                qbits[BPC-1-j]   = 1'b1;
            end
            part = trial[XLEN-1:0];
        end
        div_rem = part;
        div_acc = (acc << BPC) | {{(2*XLEN-BPC){1'b0}}, qbits};
    end

    // Final result: pick source, fix sign over the full width, then choose the half.
    always_comb begin
        src        = (out_sel == SEL_REM) ? rem : acc;
        signed_src = negate ? -src : src;
        if (special)
            final_result = acc[XLEN-1:0];
        else if (out_sel == SEL_HI)
            final_result = signed_src[2*XLEN-1:XLEN];
        else
            final_result = signed_src[XLEN-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    // Next state and handshake outputs; kill wins everywhere.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !kill) begin
                    accept     = 1'b1;
                    next_state = special_cap ? S_SETUP : S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (kill)                 next_state = S_IDLE;
                else if (counter == '0)   next_state = S_SETUP;
            end
            S_SETUP: begin
                next_state = kill ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                resp_valid = !kill;
                if (kill || resp_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath registers: load on accept, iterate in COMPUTE, latch result in SETUP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter <= '0;
            op_div  <= 1'b0;
            negate  <= 1'b0;
            special <= 1'b0;
            out_sel <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            rem     <= '0;
            result  <= '0;
        end else if (accept) begin
            counter <= CNT_W'(ITER - 1);
            op_div  <= is_divrem;
            negate  <= negate_cap;
            special <= special_cap;
            out_sel <= req_out_sel;
            a_reg   <= abs_1;
            b_reg   <= abs_2;
            acc     <= special_cap ? {{XLEN{1'b0}}, special_val} : '0;
            rem     <= '0;
        end else if (state == S_COMPUTE) begin
            counter <= counter - CNT_W'(1);
            if (op_div) begin
                a_reg <= a_reg << BPC;
                acc   <= div_acc;
                rem   <= {{XLEN{1'b0}}, div_rem};
            end else begin
                b_reg <= b_reg << BPC;
                acc   <= mul_acc;
            end
        end else if (state == S_SETUP) begin
            result <= final_result;
        end
    end

endmodule
